// File: rtl/ifetch.sv
// Instruction fetch unit: drives the PC and issues one-outstanding word requests
// to instruction memory. A small prefetch FIFO feeds decode, and a redirect
// flushes the FIFO and restarts fetch at the target.
// Optional: define IFETCH_ILLEGAL_CHECK_EN to flag non-32-bit encodings on `illegal`.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [4:0]  opcode,
    output logic [2:0]  func3,
    output logic [6:0]  func7,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        illegal
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {IDLE, BUSY, KILL} state_e;

    state_e        state_q, state_d;
    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   tgt_q, tgt_d;
    logic [31:0]   word_q [DEPTH];
    logic [31:0]   word_d [DEPTH];
    logic [31:0]   epc_q  [DEPTH];
    logic [31:0]   epc_d  [DEPTH];
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          push;
    logic          pop;
    logic [CW-1:0] cnt_after_push;
    logic [31:0]   redir_al;

    assign redir_al       = redirect_pc & 32'hFFFF_FFFC;
    assign pop            = dec_valid & dec_ready;
    assign cnt_after_push = cnt_q + CW'(1) - CW'(pop);

    // Fetch FSM next state, fetch PC, pending target and FIFO bookkeeping
    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        tgt_d   = tgt_q;
        word_d  = word_q;
        epc_d   = epc_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        cnt_d   = cnt_q;
        push    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (redirect) begin
                    fpc_d   = redir_al;
                    state_d = BUSY;
                end else if (cnt_q < CW'(DEPTH)) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (redirect) begin
                    if (imem_ack) begin
                        fpc_d = redir_al;
                    end else begin
                        tgt_d   = redir_al;
                        state_d = KILL;
                    end
                end else if (imem_ack) begin
                    push  = 1'b1;
                    fpc_d = fpc_q + 32'd4;
                    if (cnt_after_push == CW'(DEPTH)) begin
                        state_d = IDLE;
                    end
                end
            end
            KILL: begin
                // The outstanding response belongs to the old stream; drop it.
                if (imem_ack) begin
                    fpc_d   = redirect ? redir_al : tgt_q;
                    state_d = BUSY;
                end else if (redirect) begin
                    tgt_d = redir_al;
                end
            end
            default: state_d = IDLE;
        endcase

        if (redirect) begin
            rptr_d = '0;
            wptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) begin
                word_d[wptr_q] = imem_rdata;
                epc_d[wptr_q]  = fpc_q;
                wptr_d         = wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    // State and FIFO registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            fpc_q   <= RESET_PC;
            tgt_q   <= RESET_PC;
            rptr_q  <= '0;
            wptr_q  <= '0;
            cnt_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                word_q[i] <= '0;
                epc_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            tgt_q   <= tgt_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            epc_q   <= epc_d;
        end
    end

    assign imem_req  = (state_q != IDLE);
    assign imem_addr = fpc_q;
    assign dec_valid = (cnt_q != '0);
    assign instr     = word_q[rptr_q];
    assign pc        = epc_q[rptr_q];
    assign opcode    = instr[6:2];
    assign func3     = instr[14:12];
    assign func7     = instr[31:25];

`ifdef IFETCH_ILLEGAL_CHECK_EN
    logic ill_q [DEPTH];
    logic ill_d [DEPTH];

    // Per-entry flag for compressed/non-32-bit encodings, captured at push
    always_comb begin
        ill_d = ill_q;
        if (push && !redirect) begin
            ill_d[wptr_q] = (imem_rdata[1:0] != 2'b11);
        end
    end

    // Illegal-flag storage alongside the FIFO entries
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ill_q[i] <= 1'b0;
            end
        end else begin
            ill_q <= ill_d;
        end
    end

    assign illegal = dec_valid & ill_q[rptr_q];
`else
    assign illegal = 1'b0;
`endif

endmodule
